// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for the 20-bit SuperSpeed CPU.
// Ports: clk, rst (sync, active-high), inst, pc_overflow in;
//   datapath strobes, mux selects, alu_select, register
//   indices, imm_offset and addr out.
module cpu_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] inst,
  input  logic        pc_overflow,
  output logic        fetch,
  output logic        alu_control,
  output logic        reg_read,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_read,
  output logic        pc_write,
  output logic        imm,
  output logic        reg_w_select,
  output logic        pc_r_select,
  output logic        pc_w_select,
  output logic        be_select,
  output logic [2:0]  alu_select,
  output logic [3:0]  dr,
  output logic [3:0]  sr1,
  output logic [3:0]  sr2,
  output logic [19:0] imm_offset,
  output logic [9:0]  addr
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMWAIT,
    WRITEBACK,
    HALT
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       alu_control;
    logic       reg_read;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_read;
    logic       pc_write;
    logic       imm;
    logic       reg_w_select;
    logic       pc_r_select;
    logic       pc_w_select;
    logic       be_select;
    logic [2:0] alu_select;
  } ctl_t;

  state_t      state;
  state_t      state_nxt;
  ctl_t        ctl;
  ctl_t        ctl_nxt;
  logic [19:0] ir;
  logic [3:0]  op;
  logic        live;
  logic        zimm;
  logic        swap;

  assign op = ir[19:16];

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:     state_nxt = DECODE;
      DECODE:    state_nxt = (op == 4'd15) ? HALT : EXECUTE;
      EXECUTE:   state_nxt = (op == 4'd6) ? MEMWAIT : FETCH;
      MEMWAIT:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = FETCH;
      HALT:      state_nxt = HALT;
      default:   state_nxt = FETCH;
    endcase
    if (pc_overflow)
      state_nxt = HALT;
  end

  // Strobes are registered: they are computed for the state being
  // entered. IR is already loaded whenever EXECUTE is next.
  always_comb begin
    ctl_nxt = '0;
    unique case (state_nxt)
      FETCH:  ctl_nxt.fetch = 1'b1;
      DECODE: ctl_nxt.reg_read = 1'b1;
      EXECUTE: begin
        case (op)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
            ctl_nxt.alu_control  = 1'b1;
            ctl_nxt.reg_write    = 1'b1;
            ctl_nxt.reg_w_select = 1'b1;
            ctl_nxt.imm          = (op == 4'd1) || (op == 4'd3);
            case (op)
              4'd2, 4'd3: ctl_nxt.alu_select = 3'b001;
              4'd4:       ctl_nxt.alu_select = 3'b010;
              4'd5:       ctl_nxt.alu_select = 3'b011;
              default:    ctl_nxt.alu_select = 3'b000;
            endcase
          end
          4'd6: ctl_nxt.mem_read = 1'b1;
          4'd7: ctl_nxt.mem_write = 1'b1;
          4'd8: begin
            ctl_nxt.pc_write    = 1'b1;
            ctl_nxt.pc_w_select = 1'b1;
            ctl_nxt.be_select   = 1'b1;
            ctl_nxt.alu_select  = 3'b111;
          end
          4'd9, 4'd10, 4'd11: begin
            ctl_nxt.pc_write    = 1'b1;
            ctl_nxt.pc_w_select = 1'b1;
            ctl_nxt.be_select   = 1'b1;
            ctl_nxt.imm         = 1'b1;
            ctl_nxt.alu_select  = 3'(op - 4'd5);
          end
          4'd12: begin
            ctl_nxt.pc_write = 1'b1;
            ctl_nxt.imm      = 1'b1;
          end
          4'd13: begin
            ctl_nxt.pc_r_select  = 1'b1;
            ctl_nxt.pc_read      = 1'b1;
            ctl_nxt.imm          = 1'b1;
            ctl_nxt.reg_write    = 1'b1;
            ctl_nxt.reg_w_select = 1'b1;
          end
          default: ;
        endcase
      end
      MEMWAIT:   ctl_nxt.mem_read = 1'b1;
      WRITEBACK: ctl_nxt.reg_write = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      ir        <= '0;
      ctl       <= '0;
      ctl.fetch <= 1'b1;
    end else begin
      state <= state_nxt;
      ctl   <= ctl_nxt;
      if (state == FETCH)
        ir <= inst;
    end
  end

  assign live = !rst && (state != HALT);

  // Branches and JR compare against zero through the ALU.
  assign zimm = (op >= 4'd9) && (op <= 4'd12);
  assign swap = zimm || (op == 4'd7);

  assign {fetch, alu_control, reg_read, reg_write,
          mem_read, mem_write, pc_read, pc_write,
          imm, reg_w_select, pc_r_select, pc_w_select,
          be_select, alu_select} = live ? ctl : '0;

  assign dr  = live ? ir[15:12] : '0;
  assign sr1 = live ? (swap ? ir[15:12] : ir[11:8]) : '0;
  assign sr2 = (live && !swap) ? ir[7:4] : '0;
  assign imm_offset =
    (live && !zimm) ? {{12{ir[7]}}, ir[7:0]} : '0;
  assign addr = live ? ir[9:0] : '0;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized self-checking bench for cpu_control_unit.
// Expected per-cycle outputs come from an instruction-level model.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] inst;
  logic        pc_overflow;
  logic        fetch, alu_control, reg_read, reg_write;
  logic        mem_read, mem_write, pc_read, pc_write;
  logic        imm, reg_w_select, pc_r_select, pc_w_select;
  logic        be_select;
  logic [2:0]  alu_select;
  logic [3:0]  dr, sr1, sr2;
  logic [19:0] imm_offset;
  logic [9:0]  addr;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .inst(inst),
    .pc_overflow(pc_overflow),
    .fetch(fetch), .alu_control(alu_control),
    .reg_read(reg_read), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .pc_read(pc_read), .pc_write(pc_write),
    .imm(imm), .reg_w_select(reg_w_select),
    .pc_r_select(pc_r_select),
    .pc_w_select(pc_w_select),
    .be_select(be_select), .alu_select(alu_select),
    .dr(dr), .sr1(sr1), .sr2(sr2),
    .imm_offset(imm_offset), .addr(addr)
  );

  always #5 clk = ~clk;

  // Bit map of obs: fetch 57, alu_control 56, reg_read 55,
  // reg_write 54, mem_read 53, mem_write 52, pc_read 51,
  // pc_write 50, imm 49, reg_w_select 48, pc_r_select 47,
  // pc_w_select 46, be_select 45, alu_select 44:42,
  // dr 41:38, sr1 37:34, sr2 33:30, imm_offset 29:10, addr 9:0.
  logic [57:0] obs;
  assign obs = {fetch, alu_control, reg_read, reg_write,
                mem_read, mem_write, pc_read, pc_write,
                imm, reg_w_select, pc_r_select, pc_w_select,
                be_select, alu_select, dr, sr1, sr2,
                imm_offset, addr};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] cur_ir;
  bit          halted;
  logic [57:0] snap [5];

  task automatic check(input string tag,
                       input logic [57:0] got,
                       input logic [57:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-instruction phases: 0 fetch, 1 decode, 2 execute,
  // 3 memory wait, 4 writeback.
  function automatic logic [15:0] strobes(input int ph,
                                          input logic [3:0] op);
    logic f, ac, rr, rw, mr, mw, pr, pw, im, rws, prs, pws, bs;
    logic [2:0] sel;
    {f, ac, rr, rw, mr, mw, pr, pw, im, rws, prs, pws, bs} = '0;
    sel = 3'b000;
    if (ph == 0) f = 1'b1;
    if (ph == 1) rr = 1'b1;
    if (ph == 3) mr = 1'b1;
    if (ph == 4) rw = 1'b1;
    if (ph == 2) begin
      if (op <= 4'd5) begin
        ac = 1'b1; rw = 1'b1; rws = 1'b1;
        im = (op == 4'd1 || op == 4'd3);
        sel = (op <= 4'd1) ? 3'd0 : (op <= 4'd3) ? 3'd1 :
              (op == 4'd4) ? 3'd2 : 3'd3;
      end
      if (op == 4'd6) mr = 1'b1;
      if (op == 4'd7) mw = 1'b1;
      if (op == 4'd8) begin
        pw = 1'b1; pws = 1'b1; bs = 1'b1; sel = 3'd7;
      end
      if (op == 4'd9)  begin pw = 1; pws = 1; bs = 1; im = 1; sel = 3'd4; end
      if (op == 4'd10) begin pw = 1; pws = 1; bs = 1; im = 1; sel = 3'd5; end
      if (op == 4'd11) begin pw = 1; pws = 1; bs = 1; im = 1; sel = 3'd6; end
      if (op == 4'd12) begin pw = 1'b1; im = 1'b1; end
      if (op == 4'd13) begin
        prs = 1'b1; pr = 1'b1; im = 1'b1; rw = 1'b1; rws = 1'b1;
      end
    end
    return {f, ac, rr, rw, mr, mw, pr, pw, im, rws, prs, pws, bs, sel};
  endfunction

  function automatic logic [41:0] fields(input logic [19:0] ir);
    int  op;
    bit  br_like, uses_dr_as_src;
    logic [19:0] io;
    op = int'(ir[19:16]);
    br_like = (op >= 9 && op <= 12);
    uses_dr_as_src = br_like || op == 7;
    io = br_like ? 20'd0 : 20'(signed'(ir[7:0]));
    return {ir[15:12],
            uses_dr_as_src ? ir[15:12] : ir[11:8],
            uses_dr_as_src ? 4'd0 : ir[7:4],
            io, ir[9:0]};
  endfunction

  function automatic logic [57:0] expect_out(input int ph,
                                             input logic [19:0] ir);
    return {strobes(ph, ir[19:16]), fields(ir)};
  endfunction

  task automatic reset_dut(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1 check("reset", obs, '0);
      @(negedge clk);
    end
    rst = 1'b0;
    cur_ir = '0;
    halted = 1'b0;
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      #1 check("halt", obs, '0);
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input logic [19:0] word,
                          input int ovf_at,
                          input int stop_at);
    int n;
    n = (word[19:16] == 4'd15) ? 2 :
        (word[19:16] == 4'd6) ? 5 : 3;
    for (int k = 0; k < n && k < stop_at; k++) begin
      #1;
      snap[k] = obs;
      check($sformatf("ph%0d_op%0d", k, word[19:16]), obs,
            expect_out(k, (k == 0) ? cur_ir : word));
      inst = word;
      pc_overflow = (k == ovf_at);
      @(negedge clk);
      cur_ir = word;
      if (k == ovf_at) begin
        halted = 1'b1;
        break;
      end
    end
    pc_overflow = 1'b0;
    if (word[19:16] == 4'd15 && stop_at >= n)
      halted = 1'b1;
  endtask

  initial begin
    logic [19:0] w;
    int r, n, ovf, stop;
    rst = 1'b1;
    inst = '0;
    pc_overflow = 1'b0;
    halted = 1'b0;
    cur_ir = '0;
    reset_dut(2);

    do_instr(20'h13205, -1, 99);
    check("first_fetch", 58'(snap[0][57]), 58'd1);
    check("decode_rr", 58'(snap[1][55]), 58'd1);
    check("addi_dr", 58'(snap[2][41:38]), 58'd3);
    check("addi_sr1", 58'(snap[2][37:34]), 58'd2);
    check("addi_imm", 58'(snap[2][29:10]), 58'h5);
    check("addi_ctl", 58'({snap[2][54], snap[2][49], snap[2][48],
                          snap[2][44:42]}), 58'b111000);

    do_instr(20'h111FF, -1, 99);
    check("sext_imm", 58'(snap[2][29:10]), 58'hFFFFF);

    do_instr(20'h6407B, -1, 99);
    check("ld_addr", 58'(snap[2][9:0]), 58'h07B);
    check("ld_mr", 58'({snap[2][53], snap[3][53]}), 58'b11);
    check("ld_wb", 58'({snap[4][54], snap[4][48]}), 58'b10);

    do_instr(20'h95210, -1, 99);
    check("beqz_sr1", 58'(snap[2][37:34]), 58'd5);
    check("beqz_addr", 58'(snap[2][9:0]), 58'h210);
    check("beqz_ctl", 58'({snap[2][50], snap[2][46], snap[2][45],
                          snap[2][44:42]}), 58'b111100);
    check("beqz_imm", 58'(snap[2][29:10]), 58'h0);

    do_instr(20'hE0000, -1, 99);
    do_instr(20'hF0000, -1, 99);
    halt_check(20);
    reset_dut(1);
    do_instr(20'hE0000, -1, 99);

    do_instr(20'h01230, 2, 99);
    halt_check(3);
    reset_dut(1);

    do_instr(20'h03456, -1, 3);
    reset_dut(1);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      w = 20'($urandom);
      w[19:16] = (r < 4) ? 4'd15 : 4'($urandom_range(0, 14));
      n = (w[19:16] == 4'd15) ? 2 : (w[19:16] == 4'd6) ? 5 : 3;
      ovf = (r >= 4 && r < 12) ? $urandom_range(0, n - 1) : -1;
      stop = (r >= 12 && r < 18) ? $urandom_range(1, n - 1) : 99;
      do_instr(w, ovf, stop);
      if (stop < 99)
        reset_dut($urandom_range(1, 2));
      else if (halted) begin
        halt_check(3);
        reset_dut(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
